// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter sharing one slave port, with round-robin or fixed
// priority arbitration, whole-tenure ownership and a stalled-strobe watchdog.
//
// state | meaning
// IDLE  | no owner, slave side quiet, waiting for a master cycle
// OWN0  | master 0 (CPU) owns the slave port until m0_cyc_i falls
// OWN1  | master 1 (DMA/debug) owns the slave port until m1_cyc_i falls
module wb_master_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255,
  parameter int TCNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_b,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,

  output logic [1:0]  gnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  localparam bit              WD_EN   = (TIMEOUT != 0);
  localparam logic [TCNT_W-1:0] TMO_VAL = TCNT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;     // 1: master 1 owned last, so master 0 wins a tie
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic owned;
  logic own_cyc;
  logic own_stb;
  logic timeout;

  always_comb begin
    owned   = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state_q)
      S_OWN0: begin
        owned   = 1'b1;
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      S_OWN1: begin
        owned   = 1'b1;
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  assign timeout = WD_EN && owned && (tcnt_q == TMO_VAL);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = ((FIXED_PRIO != 0) || last_q) ? S_OWN0 : S_OWN1;
        end else if (m0_cyc_i) begin
          state_d = S_OWN0;
        end else if (m1_cyc_i) begin
          state_d = S_OWN1;
        end
      end
      S_OWN0: begin
        if (!m0_cyc_i) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end
      end
      S_OWN1: begin
        if (!m1_cyc_i) begin
          state_d = S_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Count only cycles where the owner is actively waiting on the slave.
  always_comb begin
    tcnt_d = '0;
    if (WD_EN && owned && own_cyc && own_stb && !s_ack_i && !s_err_i && !timeout) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Routing is purely combinational so the data phase sees no extra latency.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state_q)
      S_OWN0: begin
        gnt_o    = 2'b01;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i && !timeout;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i && !timeout;
        m0_err_o = s_err_i || timeout;
      end
      S_OWN1: begin
        gnt_o    = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i && !timeout;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i && !timeout;
        m1_err_o = s_err_i || timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: one round-robin and one fixed-priority instance share
// the same stimulus; a transaction-level model predicts every output each cycle.
module tb_wb_master_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_b;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] s_dat_in;
  logic        s_ack;
  logic        s_err;

  // first index: instance (0 round-robin, 1 fixed priority); second: master
  logic [31:0] o_m_dat [2][2];
  logic        o_m_ack [2][2];
  logic        o_m_err [2][2];
  logic [31:0] o_s_adr [2];
  logic [31:0] o_s_dat [2];
  logic [3:0]  o_s_sel [2];
  logic        o_s_we  [2];
  logic        o_s_cyc [2];
  logic        o_s_stb [2];
  logic [1:0]  o_gnt   [2];

  int vectors     = 0;
  int miscompares = 0;

  // model: owner (-1 none), last owner, cycles the owner's strobe has waited
  int own  [2];
  int last [2];
  int wt   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_master_arbiter #(.FIXED_PRIO(g), .TIMEOUT(TMO), .TCNT_W(8)) u_dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .m0_adr_i (m_adr[0]),
      .m0_dat_i (m_dat[0]),
      .m0_dat_o (o_m_dat[g][0]),
      .m0_sel_i (m_sel[0]),
      .m0_we_i  (m_we[0]),
      .m0_cyc_i (m_cyc[0]),
      .m0_stb_i (m_stb[0]),
      .m0_ack_o (o_m_ack[g][0]),
      .m0_err_o (o_m_err[g][0]),
      .m1_adr_i (m_adr[1]),
      .m1_dat_i (m_dat[1]),
      .m1_dat_o (o_m_dat[g][1]),
      .m1_sel_i (m_sel[1]),
      .m1_we_i  (m_we[1]),
      .m1_cyc_i (m_cyc[1]),
      .m1_stb_i (m_stb[1]),
      .m1_ack_o (o_m_ack[g][1]),
      .m1_err_o (o_m_err[g][1]),
      .s_adr_o  (o_s_adr[g]),
      .s_dat_o  (o_s_dat[g]),
      .s_dat_i  (s_dat_in),
      .s_sel_o  (o_s_sel[g]),
      .s_we_o   (o_s_we[g]),
      .s_cyc_o  (o_s_cyc[g]),
      .s_stb_o  (o_s_stb[g]),
      .s_ack_i  (s_ack),
      .s_err_i  (s_err),
      .gnt_o    (o_gnt[g])
    );
  end

  task automatic cmp(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, d, $time, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    for (int k = 0; k < 2; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0;
      m_we[k]  = 1'b0; m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
    end
    s_dat_in = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; last[d] = 1; wt[d] = 0;
    end
  endtask

  task automatic check_dut(input int d);
    int          o;
    bit          tmo;
    logic [31:0] e_adr, e_dat, e_mdat;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_stb, e_ack, e_err;
    o     = own[d];
    tmo   = (o >= 0) && (wt[d] == TMO);
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    if (o >= 0) begin
      e_adr = m_adr[o]; e_dat = m_dat[o]; e_sel = m_sel[o];
      e_we  = m_we[o];  e_cyc = m_cyc[o]; e_stb = m_stb[o] && !tmo;
    end
    cmp("gnt",   d, 32'(o_gnt[d]),   (o < 0) ? 32'd0 : (32'd1 << o));
    cmp("s_adr", d, o_s_adr[d],      e_adr);
    cmp("s_dat", d, o_s_dat[d],      e_dat);
    cmp("s_sel", d, 32'(o_s_sel[d]), 32'(e_sel));
    cmp("s_we",  d, 32'(o_s_we[d]),  32'(e_we));
    cmp("s_cyc", d, 32'(o_s_cyc[d]), 32'(e_cyc));
    cmp("s_stb", d, 32'(o_s_stb[d]), 32'(e_stb));
    for (int k = 0; k < 2; k++) begin
      e_mdat = (o == k) ? s_dat_in : 32'd0;
      e_ack  = (o == k) && s_ack && !tmo;
      e_err  = (o == k) && (s_err || tmo);
      cmp($sformatf("m%0d_dat", k), d, o_m_dat[d][k],      e_mdat);
      cmp($sformatf("m%0d_ack", k), d, 32'(o_m_ack[d][k]), 32'(e_ack));
      cmp($sformatf("m%0d_err", k), d, 32'(o_m_err[d][k]), 32'(e_err));
    end
  endtask

  task automatic model_step(input int d);
    int  o;
    bit  tmo;
    o   = own[d];
    tmo = (o >= 0) && (wt[d] == TMO);
    if (o < 0) begin
      wt[d] = 0;
      if (m_cyc[0] && m_cyc[1])
        own[d] = (d == 1) ? 0 : ((last[d] == 0) ? 1 : 0);
      else if (m_cyc[0])
        own[d] = 0;
      else if (m_cyc[1])
        own[d] = 1;
    end else if (!m_cyc[o]) begin
      last[d] = o;
      own[d]  = -1;
      wt[d]   = 0;
    end else if (m_stb[o] && !s_ack && !s_err && !tmo) begin
      wt[d] = wt[d] + 1;
    end else begin
      wt[d] = 0;
    end
  endtask

  // eval: settle to the falling edge and check both instances against the model
  task automatic eval();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_dut(d);
  endtask

  // adv: commit the model for this cycle, take the rising edge, step off it
  task automatic adv();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_async);
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    if (check_async) begin
      for (int d = 0; d < 2; d++) begin
        cmp("rst_async_s_cyc", d, 32'(o_s_cyc[d]),    32'd0);
        cmp("rst_async_s_stb", d, 32'(o_s_stb[d]),    32'd0);
        cmp("rst_async_gnt",   d, 32'(o_gnt[d]),      32'd0);
        cmp("rst_async_m1ack", d, 32'(o_m_ack[d][1]), 32'd0);
      end
    end
    zero_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    zero_inputs();
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp("reset_gnt",   d, 32'(o_gnt[d]),   32'd0);
      cmp("reset_s_cyc", d, 32'(o_s_cyc[d]), 32'd0);
      cmp("reset_s_we",  d, 32'(o_s_we[d]),  32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // single master read with a slave acking two cycles after strobe
    m_adr[0] = 32'h0300_0000; m_sel[0] = 4'hf; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    eval();
    cmp("single_gnt_idle", 0, 32'(o_gnt[0]), 32'd0);
    adv();
    eval();
    cmp("single_gnt", 0, 32'(o_gnt[0]), 32'd1);
    adv();
    eval();
    adv();
    s_ack = 1'b1; s_dat_in = 32'h1234_5678;
    eval();
    for (int d = 0; d < 2; d++) begin
      cmp("single_rdata", d, o_m_dat[d][0],      32'h1234_5678);
      cmp("single_ack",   d, 32'(o_m_ack[d][0]), 32'd1);
      cmp("single_m1ack", d, 32'(o_m_ack[d][1]), 32'd0);
    end
    adv();
    zero_inputs();
    eval(); adv();
    eval();
    cmp("single_release", 0, 32'(o_gnt[0]), 32'd0);
    adv();

    // simultaneous request after reset, then round-robin handover
    do_reset(1'b0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    eval(); adv();
    s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval();
      cmp("rr_first_m0", 0, 32'(o_gnt[0]), 32'd1);
      adv();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    eval();
    cmp("rr_hold_01", 0, 32'(o_gnt[0]), 32'd1);
    adv();
    eval();
    cmp("rr_idle_00", 0, 32'(o_gnt[0]), 32'd0);
    adv();
    s_ack = 1'b1;
    eval();
    cmp("rr_then_10", 0, 32'(o_gnt[0]), 32'd2);
    adv();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    eval(); adv();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    eval(); adv();
    eval();
    cmp("rr_tie_again_m0", 0, 32'(o_gnt[0]), 32'd1);
    adv();

    // fixed priority: m0 re-requests in IDLE every tenure and always wins
    do_reset(1'b0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    eval(); adv();
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1;
      eval();
      cmp("fp_m0_owns", 1, 32'(o_gnt[1]), 32'd1);
      cmp("fp_m1_noack", 1, 32'(o_m_ack[1][1]), 32'd0);
      adv();
      s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      eval(); adv();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      eval();
      cmp("fp_idle", 1, 32'(o_gnt[1]), 32'd0);
      adv();
    end

    // watchdog: m1 strobes into a silent slave
    do_reset(1'b0);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_0100;
    eval(); adv();
    for (int k = 0; k < 11; k++) begin
      eval();
      for (int d = 0; d < 2; d++) begin
        cmp($sformatf("wd_err_c%0d", k), d, 32'(o_m_err[d][1]), 32'((k % 5) == 4));
        cmp($sformatf("wd_stb_c%0d", k), d, 32'(o_s_stb[d]),    32'((k % 5) != 4));
      end
      adv();
    end
    s_ack = 1'b1;
    eval();
    adv();

    // lock during tenure: m1 requests throughout ten m0 accesses
    do_reset(1'b0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    eval(); adv();
    for (int i = 0; i < 20; i++) begin
      s_ack = (i % 2) == 1;
      eval();
      for (int d = 0; d < 2; d++) cmp("lock_gnt_01", d, 32'(o_gnt[d]), 32'd1);
      adv();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    eval(); adv();
    eval(); adv();
    eval();
    for (int d = 0; d < 2; d++) cmp("lock_then_m1", d, 32'(o_gnt[d]), 32'd2);
    adv();

    // reset in the middle of an m1 write
    do_reset(1'b0);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = 32'h0100_0040; m_dat[1] = 32'hcafe_f00d; m_sel[1] = 4'h3;
    eval(); adv();
    eval(); adv();
    do_reset(1'b1);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    eval(); adv();
    eval();
    for (int d = 0; d < 2; d++) cmp("post_rst_tie_m0", d, 32'(o_gnt[d]), 32'd1);
    adv();

    // randomized traffic against the model
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_cyc[k]) m_cyc[k] = ($urandom_range(7) != 0);
        else          m_cyc[k] = ($urandom_range(2) == 0);
        m_stb[k] = m_cyc[k] && ($urandom_range(9) < 7);
        m_adr[k] = $urandom;
        m_dat[k] = $urandom;
        m_sel[k] = 4'($urandom);
        m_we[k]  = 1'($urandom);
      end
      s_dat_in = $urandom;
      s_ack    = ($urandom_range(9) < 3);
      s_err    = ($urandom_range(19) == 0);
      eval();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
